rr_arb4way16: RTL and testbench



---
 rtl/arb_pkg.sv | 29 ++
 rtl/mux4way16.sv | 23 ++
 rtl/rr_arb4way16.sv | 131 +++++++++++++
 tb/tb_rr_arb4way16.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types, sizes and the round-robin search for the 4-way arbiter.
package arb_pkg;

  localparam int CH_W = 2;
  localparam int NCH  = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Returns {found, index}. The search starts at ptr and moves upward with
  // wrap. It walks the offsets from the far end back to the start, so the
  // requester nearest to ptr is the one left in the result.
  function automatic logic [CH_W:0] rr_pick(input logic [NCH-1:0]  req,
                                            input logic [CH_W-1:0] ptr);
    logic [CH_W:0]   res;
    logic [CH_W-1:0] idx;
    res = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = ptr + CH_W'(k);
      if (req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux4way16.sv
// Four-input word selector. sel picks which of a..d drives y.
module mux4way16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);

  // Plain combinational select.
  always_comb begin
    case (sel)
      2'd0:    y = a;
      2'd1:    y = b;
      2'd2:    y = c;
      default: y = d;
    endcase
  end

endmodule

// File: rtl/rr_arb4way16.sv
// Registered round-robin arbiter. It merges four valid/ready sources into one
// output stage. A source that presents a word with last=0 keeps the grant
// until it delivers a word with last=1.
module rr_arb4way16
  import arb_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic [WIDTH-1:0] inp3,
  input  logic [WIDTH-1:0] inp4,
  input  logic [NCH-1:0]   val,
  input  logic [NCH-1:0]   last,
  output logic [NCH-1:0]   rdy,
  output logic [WIDTH-1:0] out,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [CH_W-1:0]  line,
  output logic             out_last
);

  state_t            state_reg, state_next;
  logic [CH_W-1:0]   lk_reg, lk_next;
  logic [CH_W-1:0]   ptr_reg;
  logic [WIDTH-1:0]  out_reg;
  logic              out_val_reg;
  logic [CH_W-1:0]   line_reg;
  logic              out_last_reg;

  logic              ld;
  logic              grant;
  logic [CH_W-1:0]   g;
  logic [CH_W:0]     pick;
  logic              xfer;
  logic [WIDTH-1:0]  mux_y;

  // The output stage can take a word when it is empty or is being drained this cycle.
  assign ld   = ~out_val_reg | out_rdy;
  assign pick = rr_pick(val, ptr_reg);

  // Grant selection. While locked, only the locked channel is considered.
  always_comb begin
    g     = pick[CH_W-1:0];
    grant = pick[CH_W];
    if (state_reg == LOCKED) begin
      g     = lk_reg;
      grant = val[lk_reg];
    end
  end

  // No handshake can complete while reset is held.
  assign xfer = ld & grant & rst_n;

  // One-hot ready to the granted source only. It does not depend on any data input.
  always_comb begin
    rdy = '0;
    if (xfer) begin
      rdy[g] = 1'b1;
    end
  end

  // Lock FSM next state. Any transfer with last=0 taken from IDLE opens a packet.
  always_comb begin
    state_next = state_reg;
    lk_next    = lk_reg;
    if (xfer) begin
      case (state_reg)
        IDLE: begin
          if (!last[g]) begin
            state_next = LOCKED;
            lk_next    = g;
          end
        end
        LOCKED: begin
          if (last[g]) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      lk_reg    <= '0;
    end else begin
      state_reg <= state_next;
      lk_reg    <= lk_next;
    end
  end

  mux4way16 #(.WIDTH(WIDTH)) u_mux (
    .a   (inp1),
    .b   (inp2),
    .c   (inp3),
    .d   (inp4),
    .sel (g),
    .y   (mux_y)
  );

  // Output register and priority pointer. An empty load keeps the old data and clears only the valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg      <= '0;
      out_val_reg  <= 1'b0;
      line_reg     <= '0;
      out_last_reg <= 1'b0;
      ptr_reg      <= '0;
    end else if (xfer) begin
      out_reg      <= mux_y;
      out_val_reg  <= 1'b1;
      line_reg     <= g;
      out_last_reg <= last[g];
      ptr_reg      <= g + 2'd1;
    end else if (ld) begin
      out_val_reg  <= 1'b0;
    end
  end

  assign out      = out_reg;
  assign out_val  = out_val_reg;
  assign line     = line_reg;
  assign out_last = out_last_reg;

endmodule

// File: tb/tb_rr_arb4way16.sv
// Self-checking bench for rr_arb4way16: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_rr_arb4way16;

  logic        clk;
  logic        rst_n;
  logic [15:0] din [4];
  logic [3:0]  val;
  logic [3:0]  last;
  logic [3:0]  rdy;
  logic [15:0] out;
  logic        out_val;
  logic        out_rdy;
  logic [1:0]  line;
  logic        out_last;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the arbiter
  int          m_ptr;
  bit          m_locked;
  int          m_lk;
  bit          m_oval;
  logic [15:0] m_out;
  int          m_line;
  bit          m_olast;
  int          m_g;
  bit          m_has;
  logic [3:0]  m_rdy;
  int          m_xch;

  rr_arb4way16 #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inp1     (din[0]),
    .inp2     (din[1]),
    .inp3     (din[2]),
    .inp4     (din[3]),
    .val      (val),
    .last     (last),
    .rdy      (rdy),
    .out      (out),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .line     (line),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_ptr    = 0;
    m_locked = 0;
    m_lk     = 0;
    m_oval   = 0;
    m_out    = 16'h0;
    m_line   = 0;
    m_olast  = 0;
    m_xch    = -1;
  endfunction

  // The locked channel if it is requesting; otherwise the first requester counting up from ptr.
  function automatic void m_grant();
    bit ld;
    m_has = 0;
    m_g   = 0;
    if (m_locked) begin
      if (val[m_lk]) begin
        m_has = 1;
        m_g   = m_lk;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (!m_has && val[(m_ptr + k) % 4]) begin
          m_has = 1;
          m_g   = (m_ptr + k) % 4;
        end
      end
    end
    ld    = !m_oval || out_rdy;
    m_rdy = (rst_n && ld && m_has) ? (4'b0001 << m_g) : 4'b0000;
  endfunction

  function automatic void m_update();
    m_xch = -1;
    if (!rst_n) return;
    if (m_rdy != 4'b0000) begin
      m_xch   = m_g;
      m_out   = din[m_g];
      m_line  = m_g;
      m_olast = last[m_g];
      m_oval  = 1;
      m_ptr   = (m_g + 1) % 4;
      if (!m_locked && !last[m_g]) begin
        m_locked = 1;
        m_lk     = m_g;
      end else if (m_locked && last[m_g]) begin
        m_locked = 0;
      end
    end else if (!m_oval || out_rdy) begin
      m_oval = 0;
    end
  endfunction

  // Compare the DUT with the model, advance one clock edge, and return at the next falling edge.
  task automatic cyc();
    #1;
    m_grant();
    chk("rdy", 32'(rdy), 32'(m_rdy));
    chk("out", 32'(out), 32'(m_out));
    chk("out_val", 32'(out_val), 32'(m_oval));
    chk("line", 32'(line), 32'(m_line));
    chk("out_last", 32'(out_last), 32'(m_olast));
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] fair_out [4];
    logic [1:0]  fair_line [4];
    bit          consumed [4];
    fair_out  = '{16'h0002, 16'h0003, 16'h0004, 16'h0001};
    fair_line = '{2'd1, 2'd2, 2'd3, 2'd0};

    rst_n   = 1'b0;
    val     = 4'b0000;
    last    = 4'b0000;
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) din[i] = 16'h0;
    m_reset();
    @(negedge clk);

    // Reset with all sources requesting
    din[0] = 16'h0001; din[1] = 16'h0002; din[2] = 16'h0003; din[3] = 16'h0004;
    val = 4'b1111; last = 4'b1111;
    #1;
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_out_val", 32'(out_val), 32'h0);
    chk("rst_line", 32'(line), 32'h0);
    chk("rst_rdy", 32'(rdy), 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("first_out", 32'(out), 32'h0001);
    chk("first_line", 32'(line), 32'h0);
    chk("first_val", 32'(out_val), 32'h1);

    // Fairness: the grant rotates through every channel
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("fair_out", 32'(out), 32'(fair_out[k]));
      chk("fair_line", 32'(line), 32'(fair_line[k]));
    end

    // Backpressure: the word holds and the next word loads on the same edge that drains it
    val = 4'b0001; din[0] = 16'hABCD;
    cyc();
    chk("bp_load", 32'(out), 32'hABCD);
    out_rdy = 1'b0; val = 4'b1111; din[1] = 16'h2BCD;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_rdy", 32'(rdy), 32'h0);
      cyc();
      chk("bp_out", 32'(out), 32'hABCD);
      chk("bp_line", 32'(line), 32'h0);
      chk("bp_val", 32'(out_val), 32'h1);
    end
    out_rdy = 1'b1;
    cyc();
    chk("bp_next_out", 32'(out), 32'h2BCD);
    chk("bp_next_line", 32'(line), 32'h1);

    // Packet lock on channel 2 while the other channels keep requesting
    last = 4'b1011; din[2] = 16'h1111;
    cyc();
    chk("lock_w1", 32'(out), 32'h1111);
    chk("lock_l1", 32'(line), 32'h2);
    din[2] = 16'h2222;
    cyc();
    chk("lock_w2", 32'(out), 32'h2222);
    chk("lock_l2", 32'(line), 32'h2);
    din[2] = 16'h3333; last = 4'b1111;
    cyc();
    chk("lock_w3", 32'(out), 32'h3333);
    chk("lock_l3", 32'(line), 32'h2);
    chk("lock_last", 32'(out_last), 32'h1);
    din[3] = 16'h4444;
    cyc();
    chk("after_lock_line", 32'(line), 32'h3);
    chk("after_lock_out", 32'(out), 32'h4444);
    din[0] = 16'h5151;
    cyc();
    chk("after_lock_line2", 32'(line), 32'h0);

    // Locked stall: channel 1 holds the lock while channel 0 waits
    val = 4'b0011; last = 4'b1101; din[1] = 16'h5555;
    cyc();
    chk("stall_lock_out", 32'(out), 32'h5555);
    chk("stall_lock_line", 32'(line), 32'h1);
    val = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("stall_rdy", 32'(rdy), 32'h0);
      cyc();
      chk("stall_val", 32'(out_val), 32'h0);
    end
    val = 4'b0011; last = 4'b1111; din[1] = 16'h6666;
    cyc();
    chk("stall_resume_out", 32'(out), 32'h6666);
    chk("stall_resume_line", 32'(line), 32'h1);

    // Asynchronous reset pulsed between edges while locked on channel 2
    val = 4'b1111; last = 4'b1011; din[2] = 16'h7777;
    cyc();
    chk("arst_lock_line", 32'(line), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out", 32'(out), 32'h0);
    chk("arst_val", 32'(out_val), 32'h0);
    chk("arst_line", 32'(line), 32'h0);
    chk("arst_last", 32'(out_last), 32'h0);
    chk("arst_rdy", 32'(rdy), 32'h0);
    m_reset();
    rst_n = 1'b1;
    last = 4'b1111;
    cyc();
    chk("arst_next_line", 32'(line), 32'h0);
    chk("arst_next_out", 32'(out), 32'h5151);

    // Randomized traffic. Each source holds its word until it is accepted.
    for (int i = 0; i < 4; i++) consumed[i] = 1;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!val[i] || consumed[i]) begin
          val[i]  = $urandom_range(1, 0) != 0;
          din[i]  = 16'($urandom);
          last[i] = $urandom_range(1, 0) != 0;
        end
        consumed[i] = 0;
      end
      out_rdy = $urandom_range(9, 0) < 7;
      cyc();
      if (m_xch >= 0) consumed[m_xch] = 1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
